// File: rtl/lock_code_checker_pkg.sv
// rtl/lock_code_checker_pkg.sv - state encodings and default timing constants for the lock code checker
package lock_code_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_EVAL    = 3'd2,
        ST_OPEN    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    localparam int DEF_CODE_LEN       = 4;
    localparam int DEF_DIGIT_W        = 4;
    localparam int DEF_MAX_TRIES      = 3;
    localparam int DEF_UNLOCK_CYCLES  = 8;
    localparam int DEF_LOCKOUT_CYCLES = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter with zero flag, shared by the OPEN and LOCKOUT states
module lock_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Saturates at zero so an idle timer never wraps.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/lock_code_checker.sv
// rtl/lock_code_checker.sv - keypad code comparator with timed unlock, failure counting and lockout
module lock_code_checker
    import lock_code_checker_pkg::*;
#(
    parameter int CODE_LEN       = DEF_CODE_LEN,
    parameter int DIGIT_W        = DEF_DIGIT_W,
    parameter int MAX_TRIES      = DEF_MAX_TRIES,
    parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        key_valid,
    input  logic [DIGIT_W-1:0]          key_digit,
    input  logic                        key_clr,
    input  logic [CODE_LEN*DIGIT_W-1:0] code_in,
    output logic                        key_ready,
    output logic [2:0]                  digit_cnt,
    output logic                        unlock,
    output logic                        err,
    output logic                        locked_out,
    output logic [1:0]                  fail_cnt
);

    localparam int TW = $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES)) + 1;
    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);

    state_e       state_q, state_d;
    logic [2:0]   digit_cnt_q, digit_cnt_d;
    logic [1:0]   fail_cnt_q, fail_cnt_d;
    logic         mismatch_q, mismatch_d;
    logic         unlock_q, unlock_d;
    logic         err_q, err_d;
    logic         locked_out_q, locked_out_d;
    logic         accept;
    logic         timer_load;
    logic [TW-1:0] timer_value;
    logic         timer_zero;
    logic [DIGIT_W-1:0] code_digit;

    lock_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    assign key_ready  = rst_n && ((state_q == ST_IDLE) || (state_q == ST_ENTRY));
    assign accept     = key_valid && key_ready;
    assign code_digit = code_in[DIGIT_W*digit_cnt_q +: DIGIT_W];

    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        mismatch_d  = mismatch_q;
        timer_load  = 1'b0;
        timer_value = UNLOCK_LOAD;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                // Abort wins over a same-cycle digit.
                if (key_clr) begin
                    state_d     = ST_IDLE;
                    digit_cnt_d = '0;
                    mismatch_d  = 1'b0;
                end else if (accept) begin
                    mismatch_d  = ((state_q == ST_ENTRY) && mismatch_q) || (key_digit != code_digit);
                    digit_cnt_d = digit_cnt_q + 3'd1;
                    state_d     = (digit_cnt_d == 3'(CODE_LEN)) ? ST_EVAL : ST_ENTRY;
                end
            end
            ST_EVAL: begin
                timer_load = 1'b1;
                if (!mismatch_q) begin
                    state_d    = ST_OPEN;
                    fail_cnt_d = '0;
                end else if (int'(fail_cnt_q) + 1 < MAX_TRIES) begin
                    state_d    = ST_FAIL;
                    fail_cnt_d = fail_cnt_q + 2'd1;
                end else begin
                    state_d     = ST_LOCKOUT;
                    fail_cnt_d  = fail_cnt_q + 2'd1;
                    timer_value = LOCKOUT_LOAD;
                end
            end
            ST_OPEN: begin
                if (timer_zero) begin
                    state_d     = ST_IDLE;
                    digit_cnt_d = '0;
                end
            end
            ST_FAIL: begin
                state_d     = ST_IDLE;
                digit_cnt_d = '0;
            end
            ST_LOCKOUT: begin
                if (timer_zero) begin
                    state_d     = ST_IDLE;
                    digit_cnt_d = '0;
                    fail_cnt_d  = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                digit_cnt_d = '0;
                mismatch_d  = 1'b0;
            end
        endcase

        unlock_d     = (state_d == ST_OPEN);
        err_d        = (state_d == ST_FAIL);
        locked_out_d = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            digit_cnt_q  <= '0;
            fail_cnt_q   <= '0;
            mismatch_q   <= 1'b0;
            unlock_q     <= 1'b0;
            err_q        <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_cnt_q  <= digit_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            mismatch_q   <= mismatch_d;
            unlock_q     <= unlock_d;
            err_q        <= err_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign digit_cnt  = digit_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign unlock     = unlock_q;
    assign err        = err_q;
    assign locked_out = locked_out_q;

endmodule

// File: tb/tb_lock_code_checker.sv
// tb/tb_lock_code_checker.sv - directed self-checking bench for lock_code_checker
module tb_lock_code_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        key_clr;
    logic [15:0] code_in;
    logic        key_ready;
    logic [2:0]  digit_cnt;
    logic        unlock;
    logic        err;
    logic        locked_out;
    logic [1:0]  fail_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int n;

    lock_code_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_clr    (key_clr),
        .code_in    (code_in),
        .key_ready  (key_ready),
        .digit_cnt  (digit_cnt),
        .unlock     (unlock),
        .err        (err),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    // Counts consecutive sampled cycles with the selected output high (0: unlock, 1: locked_out).
    task automatic run_while(input int sel, input logic hold_key, output int cnt);
        cnt = 0;
        while (((sel == 0) ? unlock : locked_out) && cnt < 100) begin
            cnt++;
            key_valid = hold_key;
            key_digit = 4'd1;
            tick();
        end
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_digit = '0;
        key_clr   = 1'b0;
        code_in   = 16'h4321;
        tick();
        tick();
        check("rst_key_ready", 32'(key_ready), 32'd0);
        check("rst_unlock", 32'(unlock), 32'd0);
        check("rst_locked_out", 32'(locked_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_key_ready", 32'(key_ready), 32'd1);
        check("idle_digit_cnt", 32'(digit_cnt), 32'd0);
        check("idle_fail_cnt", 32'(fail_cnt), 32'd0);

        // 1: correct code
        press(4'd1);
        press(4'd2);
        check("s1_digit_cnt2", 32'(digit_cnt), 32'd2);
        press(4'd3);
        press(4'd4);
        check("s1_eval_key_ready", 32'(key_ready), 32'd0);
        check("s1_eval_unlock", 32'(unlock), 32'd0);
        tick();
        check("s1_unlock", 32'(unlock), 32'd1);
        check("s1_fail_cnt", 32'(fail_cnt), 32'd0);
        run_while(0, 1'b0, n);
        check("s1_unlock_len", 32'(n), 32'd8);
        check("s1_digit_cnt_after", 32'(digit_cnt), 32'd0);
        check("s1_key_ready_after", 32'(key_ready), 32'd1);

        // 2: wrong code
        enter4(4'd1, 4'd2, 4'd9, 4'd4);
        tick();
        check("s2_err", 32'(err), 32'd1);
        check("s2_fail_cnt", 32'(fail_cnt), 32'd1);
        check("s2_unlock", 32'(unlock), 32'd0);
        tick();
        check("s2_err_pulse", 32'(err), 32'd0);
        check("s2_key_ready", 32'(key_ready), 32'd1);

        // 3: three failures from a clean count trigger lockout
        do_reset();
        enter4(4'd0, 4'd2, 4'd3, 4'd4);
        tick();
        check("s3_err1", 32'(err), 32'd1);
        tick();
        enter4(4'd1, 4'd2, 4'd3, 4'd5);
        tick();
        check("s3_err2", 32'(err), 32'd1);
        check("s3_fail_cnt2", 32'(fail_cnt), 32'd2);
        tick();
        enter4(4'd4, 4'd3, 4'd2, 4'd1);
        tick();
        check("s3_locked_out", 32'(locked_out), 32'd1);
        check("s3_no_err", 32'(err), 32'd0);
        check("s3_key_ready", 32'(key_ready), 32'd0);
        run_while(1, 1'b1, n);
        check("s3_lockout_len", 32'(n), 32'd16);
        check("s3_fail_cnt_after", 32'(fail_cnt), 32'd0);
        check("s3_digit_cnt_after", 32'(digit_cnt), 32'd0);
        check("s3_key_ready_after", 32'(key_ready), 32'd1);

        // 4: abort with simultaneous digit, fail_cnt preserved
        enter4(4'd9, 4'd2, 4'd3, 4'd4);
        tick();
        tick();
        check("s4_fail_pre", 32'(fail_cnt), 32'd1);
        press(4'd1);
        press(4'd2);
        key_clr   = 1'b1;
        key_valid = 1'b1;
        key_digit = 4'd3;
        tick();
        key_clr   = 1'b0;
        key_valid = 1'b0;
        check("s4_clr_digit_cnt", 32'(digit_cnt), 32'd0);
        check("s4_clr_key_ready", 32'(key_ready), 32'd1);
        check("s4_clr_fail_cnt", 32'(fail_cnt), 32'd1);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        tick();
        check("s4_unlock", 32'(unlock), 32'd1);
        check("s4_fail_cleared", 32'(fail_cnt), 32'd0);

        // 5: reset mid-OPEN at unlock cycle 3
        tick();
        tick();
        check("s5_open_cycle3", 32'(unlock), 32'd1);
        rst_n = 1'b0;
        tick();
        check("s5_rst_unlock", 32'(unlock), 32'd0);
        check("s5_rst_digit_cnt", 32'(digit_cnt), 32'd0);
        check("s5_rst_fail_cnt", 32'(fail_cnt), 32'd0);
        check("s5_rst_key_ready", 32'(key_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check("s5_post_key_ready", 32'(key_ready), 32'd1);
        check("s5_post_unlock", 32'(unlock), 32'd0);
        press(4'd1);
        press(4'd2);
        check("s5_entry_cnt", 32'(digit_cnt), 32'd2);
        rst_n = 1'b0;
        tick();
        check("s5_entry_rst_cnt", 32'(digit_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // 6: wrong then right; strobes in EVAL/OPEN are not counted
        enter4(4'd1, 4'd1, 4'd3, 4'd4);
        tick();
        check("s6_fail1", 32'(fail_cnt), 32'd1);
        tick();
        press(4'd1);
        press(4'd2);
        press(4'd3);
        key_valid = 1'b1;
        key_digit = 4'd4;
        tick();
        key_digit = 4'd5;
        tick();
        check("s6_unlock", 32'(unlock), 32'd1);
        check("s6_fail0", 32'(fail_cnt), 32'd0);
        check("s6_eval_cnt", 32'(digit_cnt), 32'd4);
        tick();
        key_valid = 1'b0;
        check("s6_open_cnt", 32'(digit_cnt), 32'd4);
        run_while(0, 1'b0, n);
        check("s6_unlock_rest", 32'(n), 32'd7);
        check("s6_digit_cnt_after", 32'(digit_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
